// File: rtl/mesh_link_pkg.sv
// Shared types for the mesh link: word width, word type and the default link depth.
package mesh_link_pkg;
    localparam int WORD_W     = 32;
    localparam int LINK_DEPTH = 4;

    typedef logic [WORD_W-1:0] word;
endpackage

// File: rtl/link_fifo.sv
// Storage array for mesh_link: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the owner's counters.
module link_fifo
    import mesh_link_pkg::*;
#(
    parameter int DEPTH = LINK_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Write the incoming word at the write pointer when a push is granted
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mesh_link.sv
// mesh_link: buffered point-to-point channel between neighbouring mesh tiles.
// Upstream send handshake in, downstream recv handshake out, DEPTH-entry FIFO between.
// Optional feature: define MESH_LINK_STATS_EN to add the saturating xfer_count port.
module mesh_link
    import mesh_link_pkg::*;
#(
    parameter int DEPTH = LINK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] send_data,
    input  logic              send_ready,
    output logic              send_done,
    output logic [WORD_W-1:0] recv_data,
    output logic              recv_valid,
    input  logic              recv_ready
`ifdef MESH_LINK_STATS_EN
    ,
    output logic [15:0]       xfer_count
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CNT_W-1:0] r_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_cnt == CNT_W'(DEPTH));
    assign w_empty = (r_cnt == '0);

    // No full bypass: a pop in the same cycle does not open a slot until the next cycle,
    // so send_done never depends on recv_ready. Held low during reset.
    assign w_push     = send_ready & ~w_full & ~rst;
    assign w_pop      = ~w_empty & recv_ready;
    assign send_done  = w_push;
    assign recv_valid = ~w_empty;

    link_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wp),
        .i_wdata (send_data),
        .i_raddr (r_rp),
        .o_rdata (recv_data)
    );

    // Pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    // Occupancy: +1 on push only, -1 on pop only, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef MESH_LINK_STATS_EN
    logic [15:0] r_xfer;

    // Delivered-word counter, saturating at all ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             r_xfer <= '0;
        else if (w_pop && r_xfer != 16'hFFFF) r_xfer <= r_xfer + 16'd1;
    end

    assign xfer_count = r_xfer;
`endif

endmodule

// File: tb/tb_mesh_link.sv
// Directed testbench for mesh_link (DEPTH=4). Inputs change 1ns after posedge,
// outputs are sampled on the falling edge.
module tb_mesh_link;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] send_data;
    logic        send_ready;
    logic        send_done;
    logic [31:0] recv_data;
    logic        recv_valid;
    logic        recv_ready;
`ifdef MESH_LINK_STATS_EN
    logic [15:0] xfer_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mesh_link #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .send_data  (send_data),
        .send_ready (send_ready),
        .send_done  (send_done),
        .recv_data  (recv_data),
        .recv_valid (recv_valid),
        .recv_ready (recv_ready)
`ifdef MESH_LINK_STATS_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; send_ready = 1'b1; send_data = 32'h1234_5678; recv_ready = 1'b0;
        #2;
        sample();
        checks++;
        if (send_done !== 1'b0) begin
            failures++; $display("FAIL reset_send_done got=%b exp=0", send_done);
        end
        checks++;
        if (recv_valid !== 1'b0) begin
            failures++; $display("FAIL reset_recv_valid got=%b exp=0", recv_valid);
        end
`ifdef MESH_LINK_STATS_EN
        checks++;
        if (xfer_count !== 16'd0) begin
            failures++; $display("FAIL reset_xfer_count got=%0d exp=0", xfer_count);
        end
`endif
        step();
        send_ready = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single;
        step(); step();
        send_ready = 1'b1; send_data = 32'hDEADBEEF;
        sample();
        checks++;
        if (send_done !== 1'b1 || recv_valid !== 1'b0) begin
            failures++; $display("FAIL single_push done=%b valid=%b exp done=1 valid=0", send_done, recv_valid);
        end
        step();
        send_ready = 1'b0; recv_ready = 1'b1;
        sample();
        checks++;
        if (recv_valid !== 1'b1 || recv_data !== 32'hDEADBEEF) begin
            failures++; $display("FAIL single_out valid=%b data=%h exp valid=1 data=deadbeef", recv_valid, recv_data);
        end
        step();
        recv_ready = 1'b0;
        sample();
        checks++;
        if (recv_valid !== 1'b0) begin
            failures++; $display("FAIL single_drained valid=%b exp=0", recv_valid);
        end
    endtask

    // Fill to full, hold 5th word, then full+pop in the same cycle: no bypass
    task automatic test_backpressure;
        step();
        recv_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_ready = 1'b1; send_data = 32'(i);
            sample();
            checks++;
            if (send_done !== (i <= 4)) begin
                failures++; $display("FAIL fill_done[%0d] got=%b exp=%b", i, send_done, (i <= 4));
            end
            if (i <= 4) step();
        end
        checks++;
        if (recv_valid !== 1'b1 || recv_data !== 32'd1) begin
            failures++; $display("FAIL fill_head valid=%b data=%0d exp valid=1 data=1", recv_valid, recv_data);
        end
        step();
        recv_ready = 1'b1;
        sample();
        checks++;
        if (send_done !== 1'b0) begin
            failures++; $display("FAIL full_pop_done got=%b exp=0", send_done);
        end
        step();
        recv_ready = 1'b0;
        sample();
        checks++;
        if (send_done !== 1'b1) begin
            failures++; $display("FAIL after_pop_done got=%b exp=1", send_done);
        end
        step();
        send_ready = 1'b0; recv_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            sample();
            checks++;
            if (recv_valid !== 1'b1 || recv_data !== 32'(i)) begin
                failures++; $display("FAIL order[%0d] valid=%b data=%0d exp valid=1 data=%0d", i, recv_valid, recv_data, i);
            end
            step();
        end
        recv_ready = 1'b0;
        sample();
        checks++;
        if (recv_valid !== 1'b0) begin
            failures++; $display("FAIL fill_drained valid=%b exp=0", recv_valid);
        end
    endtask

    task automatic test_stream;
        int bad;
        bad = 0;
        step();
        recv_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send_ready = 1'b1; send_data = 32'(i);
            sample();
            if (send_done !== 1'b1) bad++;
            if (i == 0 && recv_valid !== 1'b0) bad++;
            if (i > 0 && (recv_valid !== 1'b1 || recv_data !== 32'(i - 1))) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL stream_cycles bad_cycles=%0d exp=0", bad);
        end
        send_ready = 1'b0;
        sample();
        checks++;
        if (recv_valid !== 1'b1 || recv_data !== 32'd99) begin
            failures++; $display("FAIL stream_last valid=%b data=%0d exp valid=1 data=99", recv_valid, recv_data);
        end
        step();
        sample();
        checks++;
        if (recv_valid !== 1'b0) begin
            failures++; $display("FAIL stream_empty valid=%b exp=0 (count not steady at 1)", recv_valid);
        end
        recv_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        step();
        recv_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_ready = 1'b1; send_data = 32'h100 + 32'(i);
            step();
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (recv_valid !== 1'b0 || send_done !== 1'b0) begin
            failures++; $display("FAIL rst_async valid=%b done=%b exp 0/0", recv_valid, send_done);
        end
        send_ready = 1'b0;
        #1 rst = 1'b0;
        sample();
        checks++;
        if (recv_valid !== 1'b0) begin
            failures++; $display("FAIL rst_empty valid=%b exp=0", recv_valid);
        end
        step();
        send_ready = 1'b1; send_data = 32'hA5A5_0001;
        step();
        send_ready = 1'b0; recv_ready = 1'b1;
        sample();
        checks++;
        if (recv_valid !== 1'b1 || recv_data !== 32'hA5A5_0001) begin
            failures++; $display("FAIL rst_first_out valid=%b data=%h exp valid=1 data=a5a50001", recv_valid, recv_data);
        end
        step();
        recv_ready = 1'b0;
        sample();
        checks++;
        if (recv_valid !== 1'b0) begin
            failures++; $display("FAIL rst_only_one valid=%b exp=0", recv_valid);
        end
    endtask

`ifdef MESH_LINK_STATS_EN
    task automatic test_stats;
        rst = 1'b1; #2 rst = 1'b0;
        step();
        recv_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_ready = 1'b1; send_data = 32'(i);
            step();
        end
        send_ready = 1'b0;
        step();
        sample();
        checks++;
        if (xfer_count !== 16'd10) begin
            failures++; $display("FAIL stats_10 got=%0d exp=10", xfer_count);
        end
        step();
        for (int i = 0; i < 65530; i++) begin
            send_ready = 1'b1; send_data = 32'(i);
            step();
        end
        send_ready = 1'b0;
        step();
        sample();
        checks++;
        if (xfer_count !== 16'hFFFF) begin
            failures++; $display("FAIL stats_sat got=%h exp=ffff", xfer_count);
        end
        recv_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_reset_mid();
`ifdef MESH_LINK_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
